// File: rtl/multiword_add_sequencer_if.sv
// Bus bundle for the multiword add sequencer: request/operands, result/status,
// and the word-serial link to the external N-bit ripple-carry adder.
interface multiword_add_sequencer_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned WORDS = 4
);
  logic                 start;
  logic [N*WORDS-1:0]   op_a;
  logic [N*WORDS-1:0]   op_b;
  logic                 cin_in;
  logic [N-1:0]         adder_a;
  logic [N-1:0]         adder_b;
  logic                 adder_cin;
  logic [N-1:0]         adder_sum;
  logic                 adder_cout;
  logic [N*WORDS-1:0]   result;
  logic                 cout;
  logic                 busy;
  logic                 done;

  modport master (
    output start, op_a, op_b, cin_in, adder_sum, adder_cout,
    input  adder_a, adder_b, adder_cin, result, cout, busy, done
  );

  modport slave (
    input  start, op_a, op_b, cin_in, adder_sum, adder_cout,
    output adder_a, adder_b, adder_cin, result, cout, busy, done
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Sequences a WORDS*N-bit add through one external N-bit adder, one word per
// cycle, least significant word first, carrying between words.
module multiword_add_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned WORDS = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  multiword_add_sequencer_if.slave bus
);
  localparam int unsigned W  = N * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic          r_carry, w_carry_nxt;
  logic [W-1:0]  r_a, w_a_nxt;
  logic [W-1:0]  r_b, w_b_nxt;
  logic [W-1:0]  r_result, w_result_nxt;
  logic          r_cout, w_cout_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [N-1:0]  r_adder_a, w_adder_a_nxt;
  logic [N-1:0]  r_adder_b, w_adder_b_nxt;
  logic          r_adder_cin, w_adder_cin_nxt;
  logic [31:0]   w_lo_cur;
  logic [31:0]   w_lo_nxt;

  assign w_lo_cur = 32'(r_k) * 32'(N);
  assign w_lo_nxt = 32'(r_k + KW'(1)) * 32'(N);

  // Adder-facing words are registered one edge ahead, so they already show word k while in RUN.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_carry_nxt     = r_carry;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_result_nxt    = r_result;
    w_cout_nxt      = r_cout;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_adder_a_nxt   = '0;
    w_adder_b_nxt   = '0;
    w_adder_cin_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.start) begin
          w_state_nxt     = S_RUN;
          w_a_nxt         = bus.op_a;
          w_b_nxt         = bus.op_b;
          w_carry_nxt     = bus.cin_in;
          w_k_nxt         = '0;
          w_busy_nxt      = 1'b1;
          w_adder_a_nxt   = bus.op_a[N-1:0];
          w_adder_b_nxt   = bus.op_b[N-1:0];
          w_adder_cin_nxt = bus.cin_in;
        end
      end
      S_RUN: begin
        w_result_nxt[w_lo_cur +: N] = bus.adder_sum;
        w_carry_nxt                 = bus.adder_cout;
        if (r_k == K_LAST) begin
          w_cout_nxt  = bus.adder_cout;
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_k_nxt         = r_k + KW'(1);
          w_adder_a_nxt   = r_a[w_lo_nxt +: N];
          w_adder_b_nxt   = r_b[w_lo_nxt +: N];
          w_adder_cin_nxt = bus.adder_cout;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_adder_a   <= '0;
      r_adder_b   <= '0;
      r_adder_cin <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_carry     <= w_carry_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_result    <= w_result_nxt;
      r_cout      <= w_cout_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_adder_a   <= w_adder_a_nxt;
      r_adder_b   <= w_adder_b_nxt;
      r_adder_cin <= w_adder_cin_nxt;
    end
  end

  assign bus.adder_a   = r_adder_a;
  assign bus.adder_b   = r_adder_b;
  assign bus.adder_cin = r_adder_cin;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: directed and random 32-bit adds (N=8, WORDS=4) against
// a plain-arithmetic reference, with an ideal combinational adder attached.
module tb_multiword_add_sequencer;
  localparam int unsigned N     = 8;
  localparam int unsigned WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  multiword_add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign {bus.adder_cout, bus.adder_sum} =
    {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + 9'(bus.adder_cin);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Carry entering word k of a+b+cin, from whole-number arithmetic.
  function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input int k);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << (8 * k)) - 64'd1;
    s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return s[8 * k];
  endfunction

  // One full add from an idle DUT; optionally fires a stray start mid-RUN.
  task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input bit stray_start, input string tag);
    logic [32:0] expv;
    logic [7:0]  wa;
    logic [7:0]  wb;
    expv = {1'b0, a} + {1'b0, b} + 33'(cin);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.cin_in = cin; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.cin_in = 1'($urandom);
    check({tag, ".busy_run"}, 64'(bus.busy), 64'd1);
    for (int k = 0; k < WORDS; k++) begin
      wa = 8'(a >> (8 * k));
      wb = 8'(b >> (8 * k));
      check($sformatf("%s.adder_a%0d", tag, k), 64'(bus.adder_a), 64'(wa));
      check($sformatf("%s.adder_b%0d", tag, k), 64'(bus.adder_b), 64'(wb));
      check($sformatf("%s.adder_cin%0d", tag, k), 64'(bus.adder_cin), 64'(carry_into(a, b, cin, k)));
      check($sformatf("%s.done_run%0d", tag, k), 64'(bus.done), 64'd0);
      bus.start = (stray_start && k == 1) ? 1'b1 : 1'b0;
      if (stray_start && k == 1) begin
        bus.op_a = ~a; bus.op_b = $urandom; bus.cin_in = ~cin;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, ".done"}, 64'(bus.done), 64'd1);
    check({tag, ".busy_done"}, 64'(bus.busy), 64'd1);
    check({tag, ".result"}, 64'(bus.result), 64'(expv[31:0]));
    check({tag, ".cout"}, 64'(bus.cout), 64'(expv[32]));
    check({tag, ".adder_a_done"}, 64'(bus.adder_a), 64'd0);
    @(negedge clk);
    check({tag, ".done_once"}, 64'(bus.done), 64'd0);
    check({tag, ".busy_idle"}, 64'(bus.busy), 64'd0);
    check({tag, ".result_hold"}, 64'(bus.result), 64'(expv[31:0]));
    check({tag, ".cout_hold"}, 64'(bus.cout), 64'(expv[32]));
    check({tag, ".adder_idle"}, 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] expv;
    int          c;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin_in = 1'b0;
    #12;
    check("reset.result", 64'(bus.result), 64'd0);
    check("reset.flags", 64'({bus.cout, bus.busy, bus.done}), 64'd0);
    check("reset.adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "inc_word0");
    run_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "ripple_all");
    run_add(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "seq_words");
    run_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones");
    run_add(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1, "stray_start");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      run_add(ra, rb, 1'($urandom), (i % 2) == 1, $sformatf("rand%0d", i));
    end

    // Abort in RUN word 2 with an asynchronous reset.
    @(negedge clk);
    bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h0123_4567; bus.cin_in = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.result", 64'(bus.result), 64'd0);
    check("abort.flags", 64'({bus.cout, bus.busy, bus.done}), 64'd0);
    check("abort.adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort.no_done%0d", i), 64'({bus.busy, bus.done}), 64'd0);
    end
    run_add(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, "after_abort");

    // Start held high: back-to-back adds, one idle cycle between them.
    ra = $urandom; rb = $urandom;
    expv = {1'b0, ra} + {1'b0, rb} + 33'd1;
    @(negedge clk);
    bus.op_a = ra; bus.op_b = rb; bus.cin_in = 1'b1; bus.start = 1'b1;
    c = 0;
    while (bus.done !== 1'b1 && c < 12) begin
      @(negedge clk);
      c++;
    end
    check("cont.first_done", 64'(bus.done), 64'd1);
    check("cont.first_latency", 64'(c), 64'd5);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      check($sformatf("cont.done%0d", i), 64'(bus.done), 64'((i % 6) == 0));
      check($sformatf("cont.busy%0d", i), 64'(bus.busy), 64'((i % 6) != 1));
      if ((i % 6) == 0)
        check($sformatf("cont.result%0d", i), 64'({bus.cout, bus.result}), 64'(expv));
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("cont.stopped", 64'({bus.busy, bus.done}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the width of the external N-bit ripple-carry adder word.
REQ-002 The block SHALL have parameter WORDS, default 4, giving the number of N-bit words per operand (WORDS >= 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin an add; sampled only in IDLE.
REQ-006 op_a  input  N*WORDS  operand A, latched on an accepted start.
REQ-007 op_b  input  N*WORDS  operand B, latched on an accepted start.
REQ-008 cin_in  input  1  carry-in of the full-width add, latched on an accepted start.
REQ-009 adder_a  output  N  word of A driven to the external adder.
REQ-010 adder_b  output  N  word of B driven to the external adder.
REQ-011 adder_cin  output  1  carry driven to the external adder.
REQ-012 adder_sum  input  N  combinational sum returned by the external adder.
REQ-013 adder_cout  input  1  combinational carry-out returned by the external adder.
REQ-014 result  output  N*WORDS  full-width sum.
REQ-015 cout  output  1  full-width carry-out.
REQ-016 busy  output  1  high in RUN and DONE.
REQ-017 done  output  1  single-cycle completion pulse.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-019 In IDLE with start=1 at a clock edge: latch op_a, op_b, cin_in; set carry register to cin_in; set word index k to 0; go to RUN.
REQ-020 In RUN: adder_a = latched A[k*N +: N]; adder_b = latched B[k*N +: N]; adder_cin = carry register.
REQ-021 At each RUN edge: result[k*N +: N] <= adder_sum; carry register <= adder_cout; k <= k+1.
REQ-022 When k = WORDS-1 at a RUN edge: also cout <= adder_cout; go to DONE. k never exceeds WORDS-1.
REQ-023 In DONE: done=1 for exactly one cycle; next state IDLE.
REQ-024 Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WORDS; total WORDS+1 cycles busy.
REQ-025 start while busy=1 SHALL be ignored; no operand relatch, no effect on the add in progress.
REQ-026 start held high through DONE SHALL be accepted at the first IDLE edge, giving back-to-back adds with one idle cycle.
REQ-027 result and cout SHALL hold their values from DONE until the next accepted start; words of result are updated one by one during RUN.
REQ-028 adder_a, adder_b, adder_cin SHALL be 0 in IDLE and DONE.
REQ-029 Operand changes on op_a/op_b/cin_in after acceptance SHALL NOT affect the add.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, k=0, carry register 0, result 0, cout 0, busy 0, done 0, adder_* outputs 0, latched operands 0.
REQ-031 Reset asserted mid-RUN SHALL abort the add with no done pulse; the first accepted start after release begins a fresh add.

Verification (N=8, WORDS=4, ideal combinational adder model connected)
REQ-032 op_a=0x000000FF, op_b=0x00000001, cin_in=0, start pulse -> done 5 cycles after acceptance edge, result=0x00000100, cout=0.
REQ-033 op_a=0xFFFFFFFF, op_b=0x00000000, cin_in=1 -> carry ripples through all 4 words; result=0x00000000, cout=1.
REQ-034 op_a=0x12345678, op_b=0x11111111, cin_in=0 -> result=0x23456789, cout=0; adder_a sequence 0x78,0x56,0x34,0x12 on consecutive RUN cycles.
REQ-035 Start pulse during RUN with different operands -> ignored; original result delivered, done pulses once.
REQ-036 rst_n low for one cycle during RUN word 2 -> all outputs 0 asynchronously, no done; subsequent start with 0x0000FFFF+0x00000001, cin 0 -> result 0x00010000, cout 0.
REQ-037 start held high continuously -> done pulses every 6 cycles; busy low for exactly one cycle between adds.
